iter_addsub: RTL and testbench

ITER_ADDSUB -- requirements
Module: iter_addsub

---
 rtl/iter_addsub.sv | 121 ++++++++++++
 tb/tb_iter_addsub.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/iter_addsub.sv
// Multi-cycle two's complement adder/subtractor: one CHUNK-wide slice per cycle, LSB first.
// Handshake: START is taken only when not in RUN; DONE is a one-cycle pulse with S/COUT/OVF/ZERO valid and held.
module iter_addsub #(
    parameter int WIDTH = 64,
    parameter int CHUNK = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] s,
    output logic             cout,
    output logic             ovf,
    output logic             zero,
    output logic [1:0]       dbg_state
);

    localparam int N  = WIDTH / CHUNK;
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIN  = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic             armed;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] a_r;
    logic [WIDTH-1:0] b_r;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] acc_nxt;
    logic             carry;
    logic [CHUNK-1:0] a_sl;
    logic [CHUNK-1:0] b_sl;
    logic [CHUNK:0]   psum;
    logic             ovf_nxt;
    logic             accept;
    logic             last;
    int               base;

    // armed stays low for the first edge after reset release so START cannot be taken there
    assign accept = start && armed && (state != RUN);
    assign last   = (cnt == CW'(N - 1));

    always_comb begin
        base    = int'(cnt) * CHUNK;
        a_sl    = a_r[base +: CHUNK];
        b_sl    = b_r[base +: CHUNK];
        psum    = {1'b0, a_sl} + {1'b0, b_sl} + {{CHUNK{1'b0}}, carry};
        acc_nxt = acc;
        acc_nxt[base +: CHUNK] = psum[CHUNK-1:0];
        // carry into the MSB recovered from the sum bit, compared with carry out of it
        ovf_nxt = a_sl[CHUNK-1] ^ b_sl[CHUNK-1] ^ psum[CHUNK-1] ^ psum[CHUNK];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = RUN;
            RUN:     if (last) state_nxt = FIN;
            FIN:     state_nxt = accept ? RUN : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy      = (state == RUN);
        done      = (state == FIN);
        dbg_state = state;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            armed <= 1'b0;
            cnt   <= '0;
            a_r   <= '0;
            b_r   <= '0;
            acc   <= '0;
            carry <= 1'b0;
            s     <= '0;
            cout  <= 1'b0;
            ovf   <= 1'b0;
            zero  <= 1'b0;
        end else begin
            armed <= 1'b1;
            if (accept) begin
                a_r   <= a;
                b_r   <= sub ? ~b : b;
                carry <= sub;
                cnt   <= '0;
                acc   <= '0;
            end else if (state == RUN) begin
                carry <= psum[CHUNK];
                acc   <= acc_nxt;
                cnt   <= last ? '0 : cnt + CW'(1);
                if (last) begin
                    s    <= acc_nxt;
                    cout <= psum[CHUNK];
                    ovf  <= ovf_nxt;
                    zero <= (acc_nxt == '0);
                end
            end
        end
    end

endmodule

// File: tb/tb_iter_addsub.sv
// Bench for iter_addsub: directed protocol/reset steps on a 64/16 instance, random sweep on 32-bit instances.
module tb_iter_addsub;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        sub = 1'b0;
    logic [63:0] a64 = '0;
    logic [63:0] b64 = '0;
    logic        start_v [4];
    logic        busy_v  [4];
    logic        done_v  [4];
    logic        cout_v  [4];
    logic        ovf_v   [4];
    logic        zero_v  [4];
    logic [1:0]  st_v    [4];
    logic [63:0] s_v     [4];
    logic [63:0] s0;
    logic [31:0] s1, s2, s3;
    int          n_chk = 0;
    int          n_fail = 0;
    int          w_of [4] = '{64, 32, 32, 32};
    int          n_of [4] = '{4, 4, 1, 32};

    always #5 clk = ~clk;

    assign s_v[0] = s0;
    assign s_v[1] = {32'd0, s1};
    assign s_v[2] = {32'd0, s2};
    assign s_v[3] = {32'd0, s3};

    iter_addsub #(.WIDTH(64), .CHUNK(16)) u0 (
        .clk(clk), .rst_n(rst_n), .start(start_v[0]), .a(a64), .b(b64), .sub(sub),
        .busy(busy_v[0]), .done(done_v[0]), .s(s0), .cout(cout_v[0]), .ovf(ovf_v[0]),
        .zero(zero_v[0]), .dbg_state(st_v[0]));
    iter_addsub #(.WIDTH(32), .CHUNK(8)) u1 (
        .clk(clk), .rst_n(rst_n), .start(start_v[1]), .a(a64[31:0]), .b(b64[31:0]), .sub(sub),
        .busy(busy_v[1]), .done(done_v[1]), .s(s1), .cout(cout_v[1]), .ovf(ovf_v[1]),
        .zero(zero_v[1]), .dbg_state(st_v[1]));
    iter_addsub #(.WIDTH(32), .CHUNK(32)) u2 (
        .clk(clk), .rst_n(rst_n), .start(start_v[2]), .a(a64[31:0]), .b(b64[31:0]), .sub(sub),
        .busy(busy_v[2]), .done(done_v[2]), .s(s2), .cout(cout_v[2]), .ovf(ovf_v[2]),
        .zero(zero_v[2]), .dbg_state(st_v[2]));
    iter_addsub #(.WIDTH(32), .CHUNK(1)) u3 (
        .clk(clk), .rst_n(rst_n), .start(start_v[3]), .a(a64[31:0]), .b(b64[31:0]), .sub(sub),
        .busy(busy_v[3]), .done(done_v[3]), .s(s3), .cout(cout_v[3]), .ovf(ovf_v[3]),
        .zero(zero_v[3]), .dbg_state(st_v[3]));

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: unsigned sum/difference for S and COUT, exact signed arithmetic for OVF
    task automatic ref_model(input int w, input logic [63:0] aa, input logic [63:0] bb, input logic ss,
                             output logic [63:0] rs, output logic rc, output logic ro, output logic rz);
        logic [63:0]        mask;
        logic [64:0]        ua, ub, ur;
        logic signed [65:0] sa, sb, sr, lim;
        mask = (w == 64) ? '1 : ((64'd1 << w) - 64'd1);
        ua   = {1'b0, aa & mask};
        ub   = {1'b0, bb & mask};
        lim  = 66'sd1 <<< (w - 1);
        sa   = $signed({2'b00, aa & mask});
        sb   = $signed({2'b00, bb & mask});
        if (aa[w-1]) sa = sa - (lim <<< 1);
        if (bb[w-1]) sb = sb - (lim <<< 1);
        if (ss) begin
            ur = ua - ub;
            rc = (ua >= ub);
            sr = sa - sb;
        end else begin
            ur = ua + ub;
            rc = (ur > {1'b0, mask});
            sr = sa + sb;
        end
        rs = ur[63:0] & mask;
        ro = (sr >= lim) || (sr < -lim);
        rz = (rs == 64'd0);
    endtask

    // Called at a negedge with start raised; returns at the negedge where DONE is seen (or budget spent)
    task automatic wait_done(input int k, output int lat, output int bcnt);
        @(posedge clk);
        @(negedge clk);
        start_v[k] = 1'b0;
        a64 = {$urandom, $urandom};
        b64 = {$urandom, $urandom};
        sub = 1'($urandom_range(0, 1));
        bcnt = int'(busy_v[k]);
        lat = 0;
        while (lat < 200) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
            if (done_v[k]) break;
            bcnt += int'(busy_v[k]);
        end
    endtask

    task automatic drive_and_check(input int k, input logic [63:0] aa, input logic [63:0] bb,
                                   input logic ss, output logic [63:0] rs);
        logic rc, ro, rz;
        int   lat, bcnt;
        a64 = aa;
        b64 = bb;
        sub = ss;
        start_v[k] = 1'b1;
        ref_model(w_of[k], aa, bb, ss, rs, rc, ro, rz);
        wait_done(k, lat, bcnt);
        check($sformatf("latency[%0d]", k), 64'(lat), 64'(n_of[k]));
        check($sformatf("busy_cycles[%0d]", k), 64'(bcnt), 64'(n_of[k]));
        check($sformatf("s[%0d]", k), s_v[k], rs);
        check($sformatf("cout[%0d]", k), 64'(cout_v[k]), 64'(rc));
        check($sformatf("ovf[%0d]", k), 64'(ovf_v[k]), 64'(ro));
        check($sformatf("zero[%0d]", k), 64'(zero_v[k]), 64'(rz));
    endtask

    task automatic do_op(input int k, input logic [63:0] aa, input logic [63:0] bb, input logic ss);
        logic [63:0] rs;
        @(negedge clk);
        drive_and_check(k, aa, bb, ss, rs);
        @(negedge clk);
        check($sformatf("done_pulse[%0d]", k), 64'(done_v[k]), 64'd0);
        check($sformatf("s_hold[%0d]", k), s_v[k], rs);
    endtask

    initial begin
        logic [63:0] rs;
        int          cyc;
        int          pulses;
        for (int i = 0; i < 4; i++) start_v[i] = 1'b0;

        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_busy", 64'(busy_v[0]), 64'd0);
        check("rst_done", 64'(done_v[0]), 64'd0);
        check("rst_s", s_v[0], 64'd0);
        check("rst_flags", {61'd0, cout_v[0], ovf_v[0], zero_v[0]}, 64'd0);
        check("rst_state", 64'(st_v[0]), 64'd0);

        start_v[0] = 1'b1;
        rst_n = 1'b1;
        @(negedge clk);
        check("no_start_at_release", 64'(busy_v[0]), 64'd0);
        start_v[0] = 1'b0;

        do_op(0, 64'd5, 64'd4, 1'b0);
        check("basic_sum", s_v[0], 64'd9);
        do_op(0, -64'sd11, 64'd9, 1'b0);
        do_op(0, -64'sd110, -64'sd33, 1'b1);
        do_op(0, 64'd53, 64'd47, 1'b1);
        do_op(0, 64'h0000_0000_0000_FFFF, 64'd1, 1'b0);
        do_op(0, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0);
        do_op(0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0);
        do_op(0, 64'h8000_0000_0000_0000, 64'd1, 1'b1);

        // START held through RUN with operands changing underneath
        @(negedge clk);
        a64 = 64'd1;
        b64 = 64'd2;
        sub = 1'b0;
        start_v[0] = 1'b1;
        repeat (3) begin
            @(negedge clk);
            a64 = {$urandom, $urandom};
            b64 = {$urandom, $urandom};
            sub = 1'($urandom_range(0, 1));
        end
        cyc = 0;
        while (!done_v[0] && cyc < 50) begin
            @(negedge clk);
            cyc++;
        end
        start_v[0] = 1'b0;
        check("held_start_s", s_v[0], 64'd3);
        pulses = 0;
        repeat (10) begin
            @(negedge clk);
            if (done_v[0]) pulses++;
        end
        check("held_start_single", 64'(pulses), 64'd0);

        // Back-to-back: new START in the DONE cycle
        @(negedge clk);
        drive_and_check(0, 64'd10, 64'd3, 1'b1, rs);
        check("b2b_first", s_v[0], 64'd7);
        drive_and_check(0, 64'h1234, 64'h4321, 1'b0, rs);
        check("b2b_second", s_v[0], 64'h5555);

        // Reset two cycles into an operation
        @(negedge clk);
        a64 = 64'd100;
        b64 = 64'd23;
        sub = 1'b0;
        start_v[0] = 1'b1;
        @(negedge clk);
        start_v[0] = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("abort_busy", 64'(busy_v[0]), 64'd0);
        check("abort_done", 64'(done_v[0]), 64'd0);
        check("abort_s", s_v[0], 64'd0);
        check("abort_flags", {61'd0, cout_v[0], ovf_v[0], zero_v[0]}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        pulses = 0;
        repeat (10) begin
            @(negedge clk);
            if (done_v[0]) pulses++;
        end
        check("abort_no_done", 64'(pulses), 64'd0);
        do_op(0, 64'd100, 64'd23, 1'b0);

        for (int k = 0; k < 4; k++) begin
            do_op(k, 64'h7FFF_FFFF, 64'd1, 1'b0);
            do_op(k, 64'h8000_0000, 64'd1, 1'b1);
            do_op(k, 64'hFFFF_FFFF, 64'hFFFF_FFFF, 1'b1);
            for (int i = 0; i < 10; i++) begin
                do_op(k, {$urandom, $urandom}, {$urandom, $urandom}, 1'($urandom_range(0, 1)));
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
